// File: rtl/i2s_pkg.sv
// Shared types and defaults for the I2S frame buffering path.
package i2s_pkg;

  localparam int WIDTH_DEF  = 16;
  localparam int DEPTH_DEF  = 8;
  localparam int DROP_CNT_W = 8;

  typedef struct packed {
    logic [WIDTH_DEF-1:0] left;
    logic [WIDTH_DEF-1:0] right;
  } frame_t;

endpackage

// File: rtl/i2s_frame_fifo_ram.sv
// Frame storage: DEPTH entries, synchronous write, asynchronous (show-ahead) read.
module frame_ram
  import i2s_pkg::*;
#(
  parameter type frame_type = frame_t,
  parameter int  DEPTH      = DEPTH_DEF,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic            sclk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  frame_type       wdata,
  input  logic [AW-1:0]   raddr,
  output frame_type       rdata
);

  frame_type mem [DEPTH];

  // NOTE: storage has no reset; validity is tracked by the pointers and count.
  always_ff @(posedge sclk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/i2s_frame_fifo.sv
// Stereo frame FIFO behind an I2S receiver: captures one frame per ws falling edge,
// presents the head frame show-ahead, and counts frames dropped while full.
module i2s_frame_fifo
  import i2s_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                    sclk,
  input  logic                    rst,
  input  logic                    ws,
  input  logic [WIDTH-1:0]        left_rx_chan,
  input  logic [WIDTH-1:0]        right_rx_chan,
  output logic [WIDTH-1:0]        out_left,
  output logic [WIDTH-1:0]        out_right,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic [DROP_CNT_W-1:0]   drop_cnt,
  input  logic                    clr_ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] left;
    logic [WIDTH-1:0] right;
  } frame_w_t;

  logic          ws_q;
  logic          capture;
  logic          pop;
  logic          full;
  logic          wr_en;
  logic          drop;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  frame_w_t      wr_frame;
  frame_w_t      head;

  // A frame is complete when ws falls: the right slot has just ended.
  assign capture  = ws_q & ~ws;
  assign out_valid = (count != '0);
  assign pop      = out_valid & out_ready;
  assign full     = (count == FULL_CNT);
  assign wr_en    = capture & (~full | pop);
  assign drop     = capture & full & ~pop;
  assign wr_frame = '{left: left_rx_chan, right: right_rx_chan};

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      ws_q   <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      ws_q <= ws;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr_en) - CW'(pop);
    end
  end

  // A drop in the clearing cycle wins, so it is never lost from the statistics.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr_ovf) begin
      overflow <= drop;
      drop_cnt <= drop ? DROP_CNT_W'(1) : '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  frame_ram #(
    .frame_type (frame_w_t),
    .DEPTH      (DEPTH)
  ) u_frame_ram (
    .sclk  (sclk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wr_frame),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Gate with out_valid so the outputs read zero, not uninitialised storage, when empty.
  assign out_left  = out_valid ? head.left  : '0;
  assign out_right = out_valid ? head.right : '0;

endmodule

// File: tb/tb_i2s_frame_fifo.sv
// Self-checking bench for i2s_frame_fifo against a queue-based frame model.
module tb_i2s_frame_fifo;
  import i2s_pkg::*;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;

  logic             sclk = 1'b0;
  logic             rst;
  logic             ws;
  logic [WIDTH-1:0] left_rx_chan;
  logic [WIDTH-1:0] right_rx_chan;
  logic [WIDTH-1:0] out_left;
  logic [WIDTH-1:0] out_right;
  logic             out_valid;
  logic             out_ready;
  logic [$clog2(DEPTH):0] count;
  logic             overflow;
  logic [7:0]       drop_cnt;
  logic             clr_ovf;

  i2s_frame_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .sclk          (sclk),
    .rst           (rst),
    .ws            (ws),
    .left_rx_chan  (left_rx_chan),
    .right_rx_chan (right_rx_chan),
    .out_left      (out_left),
    .out_right     (out_right),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .count         (count),
    .overflow      (overflow),
    .drop_cnt      (drop_cnt),
    .clr_ovf       (clr_ovf)
  );

  always #5 sclk = ~sclk;

  // Reference model: a bounded queue of frames plus the overflow statistics.
  frame_t m_q[$];
  logic   m_ws_prev;
  logic   m_ovf;
  int     m_drops;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("count", 32'(count), 32'(m_q.size()));
    check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      check("out_left", 32'(out_left), 32'(m_q[0].left));
      check("out_right", 32'(out_right), 32'(m_q[0].right));
    end
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drops));
  endtask

  // One sclk cycle: drive inputs, advance the model, then compare after the edge.
  task automatic cycle(input logic w, input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r,
                       input logic rdy, input logic clr);
    logic cap, pop_m, drop_m;
    ws = w; left_rx_chan = l; right_rx_chan = r; out_ready = rdy; clr_ovf = clr;
    cap    = m_ws_prev && !w;
    pop_m  = (m_q.size() != 0) && rdy;
    drop_m = cap && (m_q.size() == DEPTH) && !pop_m;
    if (pop_m) void'(m_q.pop_front());
    if (cap && !drop_m) m_q.push_back('{left: l, right: r});
    if (clr) begin
      m_ovf = 1'b0;
      m_drops = 0;
    end
    if (drop_m) begin
      m_ovf = 1'b1;
      if (m_drops < 255) m_drops++;
    end
    m_ws_prev = w;
    @(posedge sclk); #1;
    check_model();
  endtask

  // I2S-like frame: right slot (ws=1) for two cycles, then the capture cycle as ws falls.
  task automatic send_frame(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r,
                            input logic rdy_idle, input logic rdy_cap, input logic clr_cap);
    cycle(1'b1, WIDTH'($urandom), WIDTH'($urandom), rdy_idle, 1'b0);
    cycle(1'b1, WIDTH'($urandom), WIDTH'($urandom), rdy_idle, 1'b0);
    cycle(1'b0, l, r, rdy_cap, clr_cap);
    cycle(1'b0, WIDTH'($urandom), WIDTH'($urandom), rdy_idle, 1'b0);
  endtask

  task automatic do_reset();
    ws = 1'b1; out_ready = 1'b0; clr_ovf = 1'b0;
    rst = 1'b1;
    #1;
    m_q.delete();
    m_ws_prev = 1'b0;
    m_ovf = 1'b0;
    m_drops = 0;
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_left", 32'(out_left), 32'd0);
    check("rst_right", 32'(out_right), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    @(posedge sclk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ws = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    left_rx_chan = '0; right_rx_chan = '0;
    @(posedge sclk); #1;
    do_reset();

    // First edge after release sees ws falling but ws_q is still 0: no capture.
    cycle(1'b0, 16'h7777, 16'h8888, 1'b0, 1'b0);
    check("no_cap_after_rst", 32'(count), 32'd0);

    // Single frame held at the head.
    send_frame(16'hdead, 16'hbeef, 1'b0, 1'b0, 1'b0);
    check("one_valid", 32'(out_valid), 32'd1);
    check("one_left", 32'(out_left), 32'hdead);
    check("one_right", 32'(out_right), 32'hbeef);
    check("one_count", 32'(count), 32'd1);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Three frames streamed straight through.
    send_frame(16'h1111, 16'h2222, 1'b1, 1'b1, 1'b0);
    send_frame(16'h3333, 16'h4444, 1'b1, 1'b1, 1'b0);
    send_frame(16'h5555, 16'h6666, 1'b1, 1'b1, 1'b0);
    check("stream_empty", 32'(count), 32'd0);

    // Overfill by two frames.
    for (int i = 0; i < DEPTH + 2; i++)
      send_frame(WIDTH'(16'h1000 + i), WIDTH'(16'h2000 + i), 1'b0, 1'b0, 1'b0);
    check("full_count", 32'(count), 32'd8);
    check("full_ovf", 32'(overflow), 32'd1);
    check("full_drop", 32'(drop_cnt), 32'd2);
    check("full_head_l", 32'(out_left), 32'h1000);
    check("full_head_r", 32'(out_right), 32'h2000);

    // Pop exactly in the capture cycle while full: no drop, newest lands at the tail.
    send_frame(16'ha5a5, 16'h5a5a, 1'b0, 1'b1, 1'b0);
    check("swap_count", 32'(count), 32'd8);
    check("swap_drop", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
    check("tail_left", 32'(out_left), 32'ha5a5);
    check("tail_right", 32'(out_right), 32'h5a5a);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Clear, then clear coinciding with a drop.
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_drop", 32'(drop_cnt), 32'd0);
    for (int i = 0; i < DEPTH; i++)
      send_frame(WIDTH'($urandom), WIDTH'($urandom), 1'b0, 1'b0, 1'b0);
    send_frame(16'hbad0, 16'hbad1, 1'b0, 1'b0, 1'b1);
    check("clr_drop_ovf", 32'(overflow), 32'd1);
    check("clr_drop_cnt", 32'(drop_cnt), 32'd1);

    // Drop counter saturates at 255.
    for (int i = 0; i < 260; i++)
      send_frame(WIDTH'($urandom), WIDTH'($urandom), 1'b0, 1'b0, 1'b0);
    check("drop_sat", 32'(drop_cnt), 32'd255);

    // Reset with three frames stored, then a clean capture afterwards.
    do_reset();
    for (int i = 0; i < 3; i++)
      send_frame(WIDTH'(16'h3000 + i), WIDTH'(16'h4000 + i), 1'b0, 1'b0, 1'b0);
    check("pre_rst_count", 32'(count), 32'd3);
    do_reset();
    send_frame(16'hc0de, 16'hf00d, 1'b0, 1'b0, 1'b0);
    check("post_rst_count", 32'(count), 32'd1);
    check("post_rst_left", 32'(out_left), 32'hc0de);
    check("post_rst_right", 32'(out_right), 32'hf00d);

    // Random ws, data, ready and clear against the model.
    for (int i = 0; i < 800; i++)
      cycle(1'($urandom), WIDTH'($urandom), WIDTH'($urandom),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 31) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
